layer_input_tracker: RTL and testbench
======================================

LAYER_INPUT_TRACKER -- requirements
Module: layer_input_tracker

Interface
REQ-001 Parameter IMG_W, default 10: input feature-map width in pixels (>=KERNEL_SIZE).
REQ-002 Parameter IMG_H, default 10: input feature-map height in rows (>=KERNEL_SIZE).
REQ-003 Parameter KERNEL_SIZE, default 3: square kernel edge of the consuming conv layer.
REQ-004 Parameter READY_LEAD, default 0: pixels subtracted from the ready threshold to absorb consumer pipeline delay.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 conv_start  input  1  frame start request; sampled only in IDLE.
REQ-008 pix_valid  input  1  previous layer has one valid output pixel this cycle.
REQ-009 abort  input  1  synchronous frame cancel.
REQ-010 row_release  input  1  consumer has finished with one input row (credit mode only).
REQ-011 layer_input_ready  output  1  consumer may start or continue convolving.
REQ-012 busy  output  1  high in BUSY and DONE.
REQ-013 frame_done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-014 pix_count  output  CW  accepted pixels this frame; CW = clog2(IMG_W*IMG_H+1).
REQ-015 row_idx / col_idx  output  clog2(IMG_H) / clog2(IMG_W)  position of the next expected pixel.
REQ-016 overrun  output  1  sticky error: pix_valid seen outside BUSY.

Function
REQ-017 States are IDLE, BUSY and DONE; IDLE->BUSY on conv_start, BUSY->DONE on acceptance of pixel number IMG_W*IMG_H, DONE->IDLE unconditionally after one cycle.
REQ-018 In BUSY each pix_valid cycle increments pix_count by 1 and advances col_idx, which wraps to 0 at IMG_W-1 while incrementing row_idx.
REQ-019 frame_done is high exactly during the single DONE cycle.
REQ-020 Entering BUSY from IDLE clears pix_count, row_idx, col_idx, the release counter and overrun.
REQ-021 T0 = IMG_W*KERNEL_SIZE + KERNEL_SIZE - READY_LEAD, clamped to IMG_W*IMG_H; defaults give T0 = 33.
REQ-022 layer_input_ready = (state != IDLE) and (pix_count >= threshold); it is combinational from registers with zero added latency.
REQ-023 pix_valid in IDLE or DONE is ignored for counting and sets overrun.
REQ-024 conv_start outside IDLE is ignored.
REQ-025 abort in BUSY or DONE forces IDLE next cycle; abort takes priority over a simultaneous pix_valid or last-pixel transition; frame_done is not issued.
REQ-026 All counters saturate and never wrap past IMG_W*IMG_H.

Reset
REQ-027 While rst is low: state = IDLE; pix_count, row_idx, col_idx, the release counter, overrun, frame_done, busy and layer_input_ready = 0.
REQ-028 Assertion of rst mid-frame abandons the frame immediately; there is no pulse on release of rst.

Configuration
REQ-029 Macro LAYER_INPUT_CREDIT_EN: when defined, the threshold = min(T0 + IMG_W*rel_rows, IMG_W*IMG_H).
REQ-030 With LAYER_INPUT_CREDIT_EN defined, rel_rows counts row_release pulses in BUSY, saturates at IMG_H, and layer_input_ready may deassert again.
REQ-031 Without LAYER_INPUT_CREDIT_EN: the threshold = T0, row_release is ignored, no release counter is built, and ready is monotonic within a frame.

Structure
REQ-032 Package layer_input_pkg holds the state encoding constants and the clog2 width helper.
REQ-033 Sub-module layer_input_pos_cnt implements the row_idx/col_idx wrap counter; all other logic stays in the top module.

Verification
REQ-034 Defaults, conv_start, then 100 consecutive pix_valid -> ready rises at the cycle pix_count=33; frame_done pulses once after pixel 100; busy is low again one cycle later.
REQ-035 pix_valid gaps (1 on, 2 off) -> pix_count and ready track accepted pixels only; col_idx wraps 9->0 with row_idx+1 at pixel 10.
REQ-036 abort at pix_count=50 together with pix_valid -> IDLE, pix_count not incremented, no frame_done; next conv_start restarts from 0.
REQ-037 pix_valid in IDLE -> overrun=1, stays 1 until the next conv_start clears it.
REQ-038 rst low at pix_count=40 -> all outputs 0 asynchronously, before the next clk edge.
REQ-039 LAYER_INPUT_CREDIT_EN, pix_count=33, row_release once -> ready drops; it rises again at pix_count=43.

Source files
------------

// File: rtl/layer_input_pkg.sv
// Shared state encoding and width helper for the layer input tracker.
package layer_input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Never returns 0 so that single-entry ranges still get a 1-bit port.
    function automatic int clog2w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/layer_input_pos_cnt.sv
// Row/column position of the next expected pixel; holds at the last pixel of the frame.
module layer_input_pos_cnt
    import layer_input_pkg::*;
#(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int RW    = clog2w(IMG_H),
    parameter int CLW   = clog2w(IMG_W)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clr,
    input  logic           i_adv,
    output logic [RW-1:0]  o_row,
    output logic [CLW-1:0] o_col
);

    logic [RW-1:0]  r_row;
    logic [CLW-1:0] r_col;
    logic           w_col_end;
    logic           w_frame_end;

    assign w_col_end   = (r_col == CLW'(IMG_W - 1));
    assign w_frame_end = w_col_end && (r_row == RW'(IMG_H - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv && !w_frame_end) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CLW'(1);
            end
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

// File: rtl/layer_input_tracker.sv
// Tracks pixels arriving from the previous layer and tells the conv consumer when enough rows are buffered.
// Optional LAYER_INPUT_CREDIT_EN: consumer row releases raise the ready threshold by one row each.
module layer_input_tracker
    import layer_input_pkg::*;
#(
    parameter int IMG_W       = 10,
    parameter int IMG_H       = 10,
    parameter int KERNEL_SIZE = 3,
    parameter int READY_LEAD  = 0,
    parameter int CW          = clog2w(IMG_W * IMG_H + 1),
    parameter int RW          = clog2w(IMG_H),
    parameter int CLW         = clog2w(IMG_W)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_conv_start,
    input  logic           i_pix_valid,
    input  logic           i_abort,
    input  logic           i_row_release,
    output logic           o_layer_input_ready,
    output logic           o_busy,
    output logic           o_frame_done,
    output logic [CW-1:0]  o_pix_count,
    output logic [RW-1:0]  o_row_idx,
    output logic [CLW-1:0] o_col_idx,
    output logic           o_overrun
);

    localparam int TOTAL  = IMG_W * IMG_H;
    localparam int T0_RAW = IMG_W * KERNEL_SIZE + KERNEL_SIZE - READY_LEAD;
    localparam int T0     = (T0_RAW > TOTAL) ? TOTAL : ((T0_RAW < 0) ? 0 : T0_RAW);

    state_t        r_state;
    logic [CW-1:0] r_pix_count;
    logic          r_overrun;
    logic [CW-1:0] w_thr;
    logic          w_start;
    logic          w_accept;
    logic          w_last;

    assign w_start  = (r_state == ST_IDLE) && i_conv_start;
    assign w_accept = (r_state == ST_BUSY) && i_pix_valid && !i_abort;
    assign w_last   = w_accept && (r_pix_count == CW'(TOTAL - 1));

`ifdef LAYER_INPUT_CREDIT_EN
    localparam int RLW = clog2w(IMG_H + 1);

    logic [RLW-1:0] r_rel_rows;
    logic [31:0]    w_thr_full;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rel_rows <= '0;
        end else if (w_start) begin
            r_rel_rows <= '0;
        end else if ((r_state == ST_BUSY) && i_row_release && (r_rel_rows < RLW'(IMG_H))) begin
            r_rel_rows <= r_rel_rows + RLW'(1);
        end
    end

    assign w_thr_full = 32'(T0) + 32'(IMG_W) * 32'(r_rel_rows);
    assign w_thr      = (w_thr_full > 32'(TOTAL)) ? CW'(TOTAL) : w_thr_full[CW-1:0];
`else
    logic w_unused_release;
    assign w_unused_release = i_row_release;
    assign w_thr            = CW'(T0);
`endif

    // Abort is checked before pixel acceptance so a cancelled cycle never counts or completes.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_pix_count <= '0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_pix_valid) r_overrun <= 1'b1;
                    if (i_conv_start) begin
                        r_state     <= ST_BUSY;
                        r_pix_count <= '0;
                        r_overrun   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else if (i_pix_valid) begin
                        if (r_pix_count < CW'(TOTAL)) r_pix_count <= r_pix_count + CW'(1);
                        if (w_last) r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (i_pix_valid) r_overrun <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    layer_input_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RW    (RW),
        .CLW   (CLW)
    ) u_pos (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_start),
        .i_adv (w_accept),
        .o_row (o_row_idx),
        .o_col (o_col_idx)
    );

    assign o_busy              = (r_state != ST_IDLE);
    assign o_frame_done        = (r_state == ST_DONE);
    assign o_layer_input_ready = o_busy && (r_pix_count >= w_thr);
    assign o_pix_count         = r_pix_count;
    assign o_overrun           = r_overrun;

endmodule

// File: tb/tb_layer_input_tracker.sv
// Scoreboard bench for layer_input_tracker at default parameters.
module tb_layer_input_tracker;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_conv_start, i_pix_valid, i_abort, i_row_release;
    logic       o_layer_input_ready, o_busy, o_frame_done, o_overrun;
    logic [6:0] o_pix_count;
    logic [3:0] o_row_idx, o_col_idx;

    typedef struct {
        int rdy;
        int busy;
        int done;
        int ovr;
        int cnt;
        int row;
        int col;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   m_state = 0;
    int   m_cnt   = 0;
    int   m_ovr   = 0;
    int   m_rel   = 0;

    always #5 i_clk = ~i_clk;

    layer_input_tracker dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_conv_start        (i_conv_start),
        .i_pix_valid         (i_pix_valid),
        .i_abort             (i_abort),
        .i_row_release       (i_row_release),
        .o_layer_input_ready (o_layer_input_ready),
        .o_busy              (o_busy),
        .o_frame_done        (o_frame_done),
        .o_pix_count         (o_pix_count),
        .o_row_idx           (o_row_idx),
        .o_col_idx           (o_col_idx),
        .o_overrun           (o_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int thr();
        int t;
`ifdef LAYER_INPUT_CREDIT_EN
        t = 33 + 10 * m_rel;
        if (t > 100) t = 100;
`else
        t = 33;
`endif
        return t;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.busy = (m_state != 0) ? 1 : 0;
        e.done = (m_state == 2) ? 1 : 0;
        e.rdy  = (m_state != 0 && m_cnt >= thr()) ? 1 : 0;
        e.ovr  = m_ovr;
        e.cnt  = m_cnt;
        e.row  = (m_cnt >= 99) ? 9 : m_cnt / 10;
        e.col  = (m_cnt >= 99) ? 9 : m_cnt % 10;
        return e;
    endfunction

    // Drive one cycle, predict the post-edge outputs, then compare after the edge.
    task automatic tick(input logic cs, input logic pv, input logic ab, input logic rr);
        exp_t e;
        i_conv_start  = cs;
        i_pix_valid   = pv;
        i_abort       = ab;
        i_row_release = rr;
        if (!i_rst) begin
            m_state = 0; m_cnt = 0; m_ovr = 0; m_rel = 0;
        end else begin
            case (m_state)
                0: begin
                    if (pv) m_ovr = 1;
                    if (cs) begin m_state = 1; m_cnt = 0; m_ovr = 0; m_rel = 0; end
                end
                1: begin
                    if (rr && m_rel < 10) m_rel++;
                    if (ab) m_state = 0;
                    else if (pv) begin
                        m_cnt++;
                        if (m_cnt == 100) m_state = 2;
                    end
                end
                default: begin
                    m_state = 0;
                    if (pv) m_ovr = 1;
                end
            endcase
        end
        q.push_back(model_out());
        @(posedge i_clk);
        #1;
        e = q.pop_front();
        chk("ready", o_layer_input_ready, e.rdy);
        chk("busy", o_busy, e.busy);
        chk("frame_done", o_frame_done, e.done);
        chk("overrun", o_overrun, e.ovr);
        chk("pix_count", o_pix_count, e.cnt);
        chk("row_idx", o_row_idx, e.row);
        chk("col_idx", o_col_idx, e.col);
        if (o_frame_done) n_done++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, o_layer_input_ready, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_frame_done, 0);
        chk({tag, "_ovr"}, o_overrun, 0);
        chk({tag, "_cnt"}, o_pix_count, 0);
        chk({tag, "_row"}, o_row_idx, 0);
        chk({tag, "_col"}, o_col_idx, 0);
    endtask

    initial begin
        i_rst = 1'b0;
        i_conv_start = 0; i_pix_valid = 0; i_abort = 0; i_row_release = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk_zero("reset");
        i_rst = 1'b1;

        // Overrun in IDLE, sticky until the next start.
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);

        // Full frame of back-to-back pixels; a mid-frame conv_start must be ignored.
        for (int i = 0; i < 100; i++) tick((i == 50) ? 1'b1 : 1'b0, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        chk("done_pulses_f1", n_done, 1);

        // Gapped pixels, then abort together with a pixel at count 50.
        tick(1, 0, 0, 0);
        while (m_cnt < 12) begin
            tick(0, 1, 0, 0);
            tick(0, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
        while (m_cnt < 50) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        chk("done_pulses_abort", n_done, 1);
        tick(1, 0, 0, 0);

        // Asynchronous reset mid-frame.
        while (m_cnt < 40) tick(0, 1, 0, 0);
        #2;
        i_rst = 1'b0;
        #1;
        chk_zero("async_rst");
        tick(0, 0, 0, 0);
        i_rst = 1'b1;
        tick(0, 0, 0, 0);

`ifdef LAYER_INPUT_CREDIT_EN
        tick(1, 0, 0, 0);
        while (m_cnt < 33) tick(0, 1, 0, 0);
        tick(0, 0, 0, 1);
        while (m_cnt < 45) tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
`endif

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
